// File: rtl/ahb_bram_ctrl.sv
// AHB-Lite zero-wait-state slave in front of a dual-port BRAM. Port A takes
// write data phases, port B takes read address phases, and same-word RAW is forwarded.
module ahb_bram_ctrl #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic [2:0]            HSIZE,
    input  logic                  HWRITE,
    input  logic [31:0]           HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [31:0]           HRDATA,
    output logic [ADDR_WIDTH-1:0] bram_addra,
    output logic [31:0]           bram_dina,
    output logic [3:0]            bram_wea,
    output logic [ADDR_WIDTH-1:0] bram_addrb,
    input  logic [31:0]           bram_doutb
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ERR1 = 2'd1;
    localparam logic [1:0] ST_ERR2 = 2'd2;

    logic                  accept_s;
    logic                  err_s;
    logic [3:0]            lanes_s;
    logic [ADDR_WIDTH-1:0] word_s;
    logic [3:0]            wea_s;
    logic                  raw_hit_s;
    logic [1:0]            state_nxt_s;
    logic [31:0]           rdata_s;
    logic                  unused_s;

    logic [1:0]            state_r;
    logic                  wr_pend_r;
    logic [ADDR_WIDTH-1:0] wr_addr_r;
    logic [3:0]            wr_lanes_r;
    logic [3:0]            fwd_lanes_r;
    logic [31:0]           fwd_data_r;
    logic                  hreadyout_r;
    logic                  hresp_r;

    assign accept_s = HSEL & HTRANS[1] & HREADY;
    assign word_s   = HADDR[ADDR_WIDTH+1:2];
    assign unused_s = ^{HADDR[31:ADDR_WIDTH+2], HTRANS[0]};

    // Byte-lane decode and alignment/size error detection for the address phase.
    always_comb begin
        lanes_s = 4'b0000;
        err_s   = 1'b0;
        case (HSIZE)
            3'd0: lanes_s = 4'b0001 << HADDR[1:0];
            3'd1: begin
                if (HADDR[1]) begin
                    lanes_s = 4'b1100;
                end else begin
                    lanes_s = 4'b0011;
                end
                err_s = HADDR[0];
            end
            3'd2: begin
                lanes_s = 4'b1111;
                err_s   = (HADDR[1:0] != 2'b00);
            end
            default: err_s = 1'b1;
        endcase
    end

    // Write enables; reset low in the data phase kills the write at that edge.
    always_comb begin
        if (wr_pend_r && HRESETn) begin
            wea_s = wr_lanes_r;
        end else begin
            wea_s = 4'b0000;
        end
    end

    assign raw_hit_s = accept_s & ~HWRITE & ~err_s & (wea_s != 4'b0000) & (word_s == wr_addr_r);

    // Two-cycle ERROR response sequencing.
    always_comb begin
        state_nxt_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && err_s) begin
                    state_nxt_s = ST_ERR1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ERR1: state_nxt_s = ST_ERR2;
            ST_ERR2: begin
                if (accept_s && err_s) begin
                    state_nxt_s = ST_ERR1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Pipeline registers: FSM, pending write, forwarding lanes and bus response.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_r     <= ST_IDLE;
            wr_pend_r   <= 1'b0;
            wr_addr_r   <= '0;
            wr_lanes_r  <= 4'b0000;
            fwd_lanes_r <= 4'b0000;
            fwd_data_r  <= 32'h0000_0000;
            hreadyout_r <= 1'b1;
            hresp_r     <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            wr_pend_r   <= accept_s & HWRITE & ~err_s;
            wr_addr_r   <= word_s;
            wr_lanes_r  <= lanes_s;
            hreadyout_r <= (state_nxt_s != ST_ERR1);
            hresp_r     <= (state_nxt_s != ST_IDLE);
            if (raw_hit_s) begin
                fwd_lanes_r <= wea_s;
                fwd_data_r  <= HWDATA;
            end else begin
                fwd_lanes_r <= 4'b0000;
                fwd_data_r  <= fwd_data_r;
            end
        end
    end

    // Per-lane merge: bytes written in the overlapping cycle override stale RAM data.
    always_comb begin
        rdata_s = bram_doutb;
        for (int i = 0; i < 4; i++) begin
            if (fwd_lanes_r[i]) begin
                rdata_s[8*i +: 8] = fwd_data_r[8*i +: 8];
            end else begin
                rdata_s[8*i +: 8] = bram_doutb[8*i +: 8];
            end
        end
    end

    assign HREADYOUT  = hreadyout_r;
    assign HRESP      = hresp_r;
    assign HRDATA     = rdata_s;
    assign bram_addra = wr_addr_r;
    assign bram_dina  = HWDATA;
    assign bram_wea   = wea_s;
    assign bram_addrb = word_s;

endmodule

// File: tb/tb_ahb_bram_ctrl.sv
// Directed and table-driven bench for ahb_bram_ctrl with a behavioural
// dual-port RAM and a byte-level reference model for the randomized stream.
module tb_ahb_bram_ctrl;

    localparam int AW = 12;

    logic          HCLK = 1'b0;
    logic          HRESETn;
    logic          HSEL;
    logic [31:0]   HADDR;
    logic [1:0]    HTRANS;
    logic [2:0]    HSIZE;
    logic          HWRITE;
    logic [31:0]   HWDATA;
    logic          HREADY;
    logic          HREADYOUT;
    logic          HRESP;
    logic [31:0]   HRDATA;
    logic [AW-1:0] bram_addra;
    logic [31:0]   bram_dina;
    logic [3:0]    bram_wea;
    logic [AW-1:0] bram_addrb;
    logic [31:0]   bram_doutb;

    bit   [31:0]   mem [0:(1<<AW)-1];
    bit   [31:0]   ref_mem [0:3];

    int n_vec  = 0;
    int n_miss = 0;

    always #5 HCLK = ~HCLK;
    assign HREADY = HREADYOUT;

    ahb_bram_ctrl #(.ADDR_WIDTH(AW)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
        .HTRANS(HTRANS), .HSIZE(HSIZE), .HWRITE(HWRITE), .HWDATA(HWDATA),
        .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
        .bram_addra(bram_addra), .bram_dina(bram_dina), .bram_wea(bram_wea),
        .bram_addrb(bram_addrb), .bram_doutb(bram_doutb)
    );

    // Behavioural BRAM: byte-write port A, read-before-write port B.
    always @(posedge HCLK) begin
        for (int b = 0; b < 4; b++) begin
            if (bram_wea[b]) mem[bram_addra][8*b +: 8] <= bram_dina[8*b +: 8];
        end
        bram_doutb <= mem[bram_addrb];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step(input logic rstn, input logic sel, input logic [1:0] trans,
                        input logic [31:0] addr, input logic [2:0] size,
                        input logic wr, input logic [31:0] wdata);
        @(posedge HCLK);
        #1;
        HRESETn = rstn; HSEL = sel; HTRANS = trans; HADDR = addr;
        HSIZE = size; HWRITE = wr; HWDATA = wdata;
        @(negedge HCLK);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] wdata);
        step(1'b1, 1'b1, 2'b10, addr, size, 1'b1, wdata);
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] wdata);
        step(1'b1, 1'b1, 2'b10, addr, 3'd2, 1'b0, wdata);
    endtask

    task automatic idle(input logic [31:0] wdata);
        step(1'b1, 1'b0, 2'b00, 32'h0000_0000, 3'd2, 1'b0, wdata);
    endtask

    logic [31:0] err_addr [0:2];
    logic [2:0]  err_size [0:2];
    logic        err_wr   [0:2];

    logic        pw, pr, act, sel_v, is_wr;
    logic [1:0]  pw_idx, idx, off, tr_v;
    logic [2:0]  sz;
    logic [3:0]  pw_lanes, lanes;
    logic [31:0] pw_data, pr_exp, cur_wdata, addr;

    initial begin
        HRESETn = 1'b0; HSEL = 1'b0; HTRANS = 2'b00; HADDR = 32'h0;
        HSIZE = 3'd2; HWRITE = 1'b0; HWDATA = 32'h0;

        step(1'b0, 1'b0, 2'b00, 32'h0, 3'd2, 1'b0, 32'h0);
        step(1'b0, 1'b0, 2'b00, 32'h0, 3'd2, 1'b0, 32'h0);
        check_eq("rst_hreadyout", 32'(HREADYOUT), 32'd1);
        check_eq("rst_hresp",     32'(HRESP),     32'd0);
        check_eq("rst_wea",       32'(bram_wea),  32'd0);

        // Plain word write then read.
        wr(32'h10, 3'd2, 32'h0);
        check_eq("w1_hreadyout", 32'(HREADYOUT), 32'd1);
        idle(32'hDEADBEEF);
        check_eq("w1_wea",   32'(bram_wea),   32'hF);
        check_eq("w1_addra", 32'(bram_addra), 32'd4);
        check_eq("w1_dina",  bram_dina,       32'hDEADBEEF);
        rd(32'h10, 32'h0);
        check_eq("r1_addrb", 32'(bram_addrb), 32'd4);
        check_eq("r1_wea",   32'(bram_wea),   32'd0);
        idle(32'h0);
        check_eq("r1_rdata",     HRDATA,         32'hDEADBEEF);
        check_eq("r1_hreadyout", 32'(HREADYOUT), 32'd1);

        // Byte and halfword lanes.
        wr(32'h10, 3'd2, 32'h0);
        wr(32'h13, 3'd0, 32'h11223344);
        check_eq("w2_wea_word", 32'(bram_wea), 32'hF);
        rd(32'h10, 32'hAA000000);
        check_eq("w2_wea_byte", 32'(bram_wea), 32'h8);
        wr(32'h12, 3'd1, 32'h0);
        check_eq("r2_byte_rdata", HRDATA, 32'hAA223344);
        idle(32'h55660000);
        check_eq("w2_wea_half", 32'(bram_wea), 32'hC);
        rd(32'h10, 32'h0);
        idle(32'h0);
        check_eq("r2_half_rdata", HRDATA, 32'h55663344);

        // Read-after-write forwarding.
        wr(32'h20, 3'd2, 32'h0);
        rd(32'h20, 32'hCAFEF00D);
        idle(32'h0);
        check_eq("raw_word", HRDATA, 32'hCAFEF00D);
        wr(32'h21, 3'd0, 32'h0);
        rd(32'h20, 32'h00007700);
        idle(32'h0);
        check_eq("raw_byte_old", HRDATA, 32'hCAFE770D);
        wr(32'h20, 3'd2, 32'h0);
        wr(32'h21, 3'd0, 32'h0);
        rd(32'h20, 32'h00007700);
        idle(32'h0);
        check_eq("raw_byte_zero", HRDATA, 32'h00007700);
        wr(32'h24, 3'd2, 32'h0);
        rd(32'h20, 32'h12345678);
        idle(32'h0);
        check_eq("nofwd_mismatch", HRDATA, 32'h00007700);

        // Error responses, each followed by a read accepted in ERR2.
        err_addr[0] = 32'h31; err_size[0] = 3'd1; err_wr[0] = 1'b1;
        err_addr[1] = 32'h32; err_size[1] = 3'd2; err_wr[1] = 1'b0;
        err_addr[2] = 32'h40; err_size[2] = 3'd3; err_wr[2] = 1'b1;
        for (int e = 0; e < 3; e++) begin
            step(1'b1, 1'b1, 2'b10, err_addr[e], err_size[e], err_wr[e], 32'h0);
            check_eq("err_addr_hresp", 32'(HRESP), 32'd0);
            idle(32'hFFFFFFFF);
            check_eq("err1_hreadyout", 32'(HREADYOUT), 32'd0);
            check_eq("err1_hresp",     32'(HRESP),     32'd1);
            check_eq("err1_wea",       32'(bram_wea),  32'd0);
            rd(32'h10, 32'hFFFFFFFF);
            check_eq("err2_hreadyout", 32'(HREADYOUT), 32'd1);
            check_eq("err2_hresp",     32'(HRESP),     32'd1);
            check_eq("err2_wea",       32'(bram_wea),  32'd0);
            idle(32'h0);
            check_eq("err_after_rdata", HRDATA,      32'h55663344);
            check_eq("err_after_hresp", 32'(HRESP),  32'd0);
        end

        // Reset during a write data phase.
        wr(32'h40, 3'd2, 32'h0);
        idle(32'h01020304);
        wr(32'h40, 3'd2, 32'h0);
        step(1'b0, 1'b0, 2'b00, 32'h0, 3'd2, 1'b0, 32'hFFFFFFFF);
        check_eq("rstmid_wea", 32'(bram_wea), 32'd0);
        idle(32'hFFFFFFFF);
        check_eq("rstmid_hreadyout", 32'(HREADYOUT), 32'd1);
        check_eq("rstmid_hresp",     32'(HRESP),     32'd0);
        check_eq("rstmid_wea_after", 32'(bram_wea),  32'd0);
        rd(32'h40, 32'h0);
        idle(32'h0);
        check_eq("rstmid_mem", HRDATA, 32'h01020304);

        // Reset aborting ERR1.
        step(1'b1, 1'b1, 2'b10, 32'h31, 3'd1, 1'b1, 32'h0);
        step(1'b0, 1'b0, 2'b00, 32'h0, 3'd2, 1'b0, 32'h0);
        idle(32'h0);
        check_eq("rsterr_hreadyout", 32'(HREADYOUT), 32'd1);
        check_eq("rsterr_hresp",     32'(HRESP),     32'd0);

        // Alternating write/read stream over four words against a byte model.
        pw = 1'b0; pr = 1'b0; pw_idx = 2'd0; pw_lanes = 4'h0; pw_data = 32'h0; pr_exp = 32'h0;
        for (int i = 0; i < 17; i++) begin
            cur_wdata = pw ? pw_data : $urandom();
            if (pw) begin
                for (int b = 0; b < 4; b++) begin
                    if (pw_lanes[b]) ref_mem[pw_idx][8*b +: 8] = pw_data[8*b +: 8];
                end
            end
            act   = (i < 16) && ($urandom_range(0, 3) != 0);
            sel_v = act ? 1'b1 : 1'($urandom_range(0, 1));
            tr_v  = act ? 2'b10 : 2'b01;
            is_wr = (i % 2 == 0);
            idx   = 2'($urandom_range(0, 3));
            sz    = 3'($urandom_range(0, 2));
            if (sz == 3'd0) begin
                off   = 2'($urandom_range(0, 3));
                lanes = 4'b0001 << off;
            end else if (sz == 3'd1) begin
                off   = {1'($urandom_range(0, 1)), 1'b0};
                lanes = off[1] ? 4'b1100 : 4'b0011;
            end else begin
                off   = 2'd0;
                lanes = 4'b1111;
            end
            addr = 32'h140 + 32'(idx) * 32'd4 + 32'(off);
            step(1'b1, sel_v, tr_v, addr, sz, is_wr, cur_wdata);
            check_eq("rnd_wea", 32'(bram_wea), pw ? 32'(pw_lanes) : 32'd0);
            if (pr) check_eq("rnd_rdata", HRDATA, pr_exp);
            pr       = act & ~is_wr;
            pr_exp   = ref_mem[idx];
            pw       = act & is_wr;
            pw_idx   = idx;
            pw_lanes = lanes;
            pw_data  = $urandom();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/ahb_bram_ctrl.md
Name: ahb_bram_ctrl

Overview:
AHB-Lite slave that sits directly upstream of the dual-port block RAM in the Cortex-M0 memory map and drives both of its ports. Port A is byte-write and takes write data phases; port B is read-only and takes read address phases. Transfers run with zero wait states. A write immediately followed by a read of the same word returns the new data via byte-lane forwarding. Unsupported sizes and misaligned transfers get the two-cycle AHB ERROR response.

Parameters:
ADDR_WIDTH, 12, word-address width of the attached RAM (2**ADDR_WIDTH 32-bit words); byte address bits [ADDR_WIDTH+1:2] are used, upper HADDR bits ignored

Ports:
HCLK  input  1  system clock; also clocks the RAM
HRESETn  input  1  synchronous active-low reset
HSEL  input  1  slave select
HADDR  input  32  byte address (address phase)
HTRANS  input  2  transfer type; bit 1 set = NONSEQ/SEQ
HSIZE  input  3  0 = byte, 1 = halfword, 2 = word
HWRITE  input  1  1 = write
HWDATA  input  32  write data (data phase)
HREADY  input  1  bus-wide ready
HREADYOUT  output  1  slave ready
HRESP  output  1  0 = OKAY, 1 = ERROR
HRDATA  output  32  read data (data phase)
bram_addra  output  ADDR_WIDTH  RAM write word address
bram_dina  output  32  RAM write data
bram_wea  output  4  RAM byte write enables
bram_addrb  output  ADDR_WIDTH  RAM read word address
bram_doutb  input  32  RAM read data, one cycle after bram_addrb

Behaviour:
- Clock and reset: single clock HCLK. Reset is synchronous and active-low on HRESETn.
- Reset values: HREADYOUT=1, HRESP=0, bram_wea=0, pending write cleared, forward lanes cleared, FSM=IDLE.
- Accept condition: an address phase is accepted when HSEL & HTRANS[1] & HREADY are all high.
- Lane decode from HSIZE and HADDR[1:0]:
  - byte: lane = 1<<HADDR[1:0]
  - half: HADDR[1] ? 4'b1100 : 4'b0011
  - word: 4'b1111
- Error condition: an accepted transfer is an error when HSIZE>=3, or half with HADDR[0]=1, or word with HADDR[1:0]!=0.
- FSM states: IDLE (no data phase, or OKAY data phase), ERR1, ERR2.
  - Accepted error transfer: next cycle is ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1), then IDLE.
  - During ERR1, HREADY is low, so no new transfer is accepted.
  - During ERR2 a transfer may be accepted normally.
  - An error transfer never writes the RAM.
- Write path:
  - Accepted OKAY write registers word address and lanes.
  - In the following cycle (data phase): bram_addra = registered address, bram_dina = HWDATA, bram_wea = registered lanes.
  - bram_wea=0 in every other cycle. Write latency is 1 cycle after the address phase.
- Read path:
  - bram_addrb = HADDR[ADDR_WIDTH+1:2] combinationally at all times.
  - RAM data returns in the data phase and HRDATA is driven from bram_doutb.
  - Read latency is 0 wait states.
- RAW forwarding:
  - Case: a read address phase coincides with a write data phase, same word, bram_wea nonzero. The RAM returns old data.
  - The block registers fwd_lanes = bram_wea and fwd_data = HWDATA at that edge.
  - In the read data phase, each byte lane is taken from fwd_data where fwd_lanes is set, otherwise from bram_doutb.
  - fwd_lanes is cleared on the next edge unless it is re-armed.
  - There is no forwarding on an address mismatch or when there is no concurrent write.
- Back-to-back: write-write, read-read and alternating sequences all sustain one transfer per cycle.
- HRDATA outside a read data phase: merged value, don't-care to the master.
- Idle/busy: HTRANS=IDLE/BUSY or HSEL=0 gives an OKAY zero-wait response and no RAM write in the next cycle.
- Reset mid-operation: HRESETn low during a write data phase suppresses that write (bram_wea=0). It also aborts ERR1/ERR2 back to IDLE.

Test Plan:
- Word write 0xDEADBEEF to 0x0000_0010, then read 0x10 -> bram_wea=4'b1111 with bram_addra=4 one cycle after the write address phase. Read returns HRDATA=0xDEADBEEF, HREADYOUT=1 throughout.
- Byte write 0xAA to 0x13 over word 0x11223344 -> wea=4'b1000; readback 0xAA223344. Halfword 0x5566 to 0x12 -> wea=4'b1100.
- Write 0xCAFEF00D to 0x20 immediately followed by a read of 0x20 (read address phase = write data phase) -> HRDATA=0xCAFEF00D. Repeat with byte write 0x77 to 0x21 over word 0x00000000 -> HRDATA=0x00007700.
- Halfword write to 0x31, word read at 0x32, and HSIZE=3 -> each gives HREADYOUT=0/HRESP=1 then HREADYOUT=1/HRESP=1, with bram_wea=0. A following valid read accepted in ERR2 returns correct data.
- Reset: assert HRESETn=0 in the data phase of a write to 0x40 -> mem[0x10] unchanged and all outputs at reset values the next cycle.
- Stream of 16 random alternating byte/half/word writes and reads with HSEL toggling -> HRDATA matches a reference byte model, and bram_wea is asserted only in write data phases.
